timer_periph: RTL
=================

# timer_periph

Memory-mapped programmable down-counter timer on the ARMv4 data bus, in the timer slot of the data-side read mux, alongside data RAM and the SMS ROM. The chipset decoder gives the write strobe. The CPU data bus gives the word offset and write data. Read data goes back through the 3:1 read mux. It extends the plain timer register with load/reload, a prescaler, a sticky expiry flag and an interrupt line.

## Interface
- WIDTH, 32, counter and data-bus width
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write strobe from chipset (timer region selected and MemWrite)
- addr  in  2  word offset, DataAdr[3:2]
- wdata  in  WIDTH  CPU write data
- rdata  out  WIDTH  read data to read mux, combinational from registered state
- irq  out  1  interrupt request

## Operation
- Registers, by offset:
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits15:8 PRESCALE. Other bits read 0.
  - 1 LOAD: reload value, full WIDTH.
  - 2 COUNT: current count, read-only. Writes are ignored.
  - 3 STATUS: bit0 EXPIRED, sticky. Writing 1 to bit0 clears it.
- Writing LOAD also copies wdata into COUNT on the same edge.
- FSM states:
  - IDLE (EN=0): COUNT holds its value. IDLE→RUN on a CTRL write with EN=1.
  - RUN: decrement on each tick.
- On a tick with COUNT==0:
  - EXPIRED is set.
  - If AUTO_RELOAD=1: COUNT←LOAD and the FSM stays in RUN.
  - Otherwise: COUNT stays 0, EN is cleared, and the FSM returns to IDLE.
- A CTRL write with EN=0 forces IDLE immediately. COUNT is preserved.
- Tick: a 1-cycle pulse from the prescaler when prescaler count == PRESCALE. The prescaler then returns to 0. So the tick period is PRESCALE+1 cycles.
- irq = EXPIRED & IRQ_EN.
- Arithmetic: COUNT is unsigned WIDTH bits. Decrementing below 0 never occurs (the 0 case is handled as above).

## Timing
- Reset values: CTRL=0, LOAD=0, COUNT=0, EXPIRED=0, prescaler=0, FSM=IDLE, irq=0. rdata returns the addressed register's reset value (0).
- Write latency: the register updates on the rising edge where we=1. rdata reflects the new value in the following cycle.
- The prescaler counter resets to 0 on any CTRL write that sets EN=1. The first tick arrives PRESCALE+1 cycles after that edge.
- With PRESCALE=0, COUNT=N, EN set at edge k:
  - COUNT==0 after edge k+N.
  - EXPIRED (and irq if enabled) is set at edge k+N+1.
- Simultaneous events:
  - STATUS clear in the same cycle as expiry: the expiry wins and EXPIRED stays 1.
  - LOAD write in the same cycle as a tick: the write wins (COUNT←wdata, no decrement).
  - CTRL write with EN=0 in the same cycle as expiry: the FSM goes to IDLE, and EXPIRED is still set.
- rst asserted mid-count returns every register to its reset value on that edge. It overrides a concurrent we.

## Configuration
- TIMER_PRESCALER_EN defined:
  - The prescaler is built.
  - CTRL[15:8] is writable and readable.
  - The tick period is PRESCALE+1 cycles.
- TIMER_PRESCALER_EN not defined:
  - No prescaler logic is built.
  - Tick is 1 every cycle in RUN.
  - CTRL[15:8] writes are ignored and those bits read 0.

## Structure
- Package timer_pkg holds:
  - the register offset constants (OFF_CTRL=0, OFF_LOAD=1, OFF_COUNT=2, OFF_STATUS=3);
  - the CTRL bit-position constants (EN, AUTO_RELOAD, IRQ_EN, PRESCALE_LSB=8, PRESCALE_MSB=15);
  - the FSM enum typedef {IDLE, RUN}.
- One sub-module, timer_prescaler:
  - ports: clk, rst, clear, en, 8-bit div, 1-bit tick out;
  - instantiated only under TIMER_PRESCALER_EN.

## Test plan
- Reset: assert rst 2 cycles, then read all 4 offsets → every read returns 0 and irq=0.
- One-shot: LOAD=5, CTRL=0x5 (EN, IRQ_EN) → COUNT reads 5,4,3,2,1,0 on successive cycles. EXPIRED=1 and irq=1 six cycles after the CTRL write. CTRL reads 0x4 and COUNT holds 0.
- Auto-reload: LOAD=2, CTRL=0x3 → COUNT sequence 2,1,0,2,1,0. EXPIRED stays set. Writing STATUS=1 clears it until the next wrap.
- Prescaler (TIMER_PRESCALER_EN): LOAD=3, CTRL=0x0301 → COUNT decrements once every 4 cycles and expires 16 cycles after enable. Without the macro, the same write expires after 4 cycles and CTRL reads 0x1.
- Collisions: STATUS clear on the expiry cycle → EXPIRED remains 1. A LOAD=9 write on a tick cycle → COUNT reads 9, not 8.
- Mid-run reset: rst at COUNT=3 in RUN → the next cycle shows all registers 0, FSM IDLE and irq=0. A COUNT write attempt afterwards → COUNT stays 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Register map, CTRL bit positions and FSM states shared by the timer peripheral.
// The CTRL read-back word is assembled here so all field positions live in one place.
package timer_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int PRESCALE_LSB     = 8;
  localparam int PRESCALE_MSB     = 15;
  localparam int STATUS_EXPIRED   = 0;

  typedef enum logic {IDLE, RUN} timerState_t;

  function automatic logic [15:0] ctrlWord(input logic en, input logic autoReload,
                                           input logic irqEn, input logic [7:0] prescale);
    logic [15:0] w;
    w = '0;
    w[CTRL_EN]                    = en;
    w[CTRL_AUTO_RELOAD]           = autoReload;
    w[CTRL_IRQ_EN]                = irqEn;
    w[PRESCALE_MSB:PRESCALE_LSB]  = prescale;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: one-cycle tick every div+1 enabled cycles; clear restarts the period.
// Tick is combinational from the counter; no backpressure.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  // A clearing cycle starts a fresh period, so it must not also emit a tick.
  assign tick = en & ~clear & (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == div) ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped down-counter timer (CTRL/LOAD/COUNT/STATUS); prescaler built under TIMER_PRESCALER_EN.
// Writes land on the strobed edge and read back next cycle; always accepts, no backpressure.
module timer_periph
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  timerState_t      state, stateNext;
  logic             ctrlEn, ctrlEnNext;
  logic             ctrlAutoReload, ctrlAutoReloadNext;
  logic             ctrlIrqEn, ctrlIrqEnNext;
  logic [WIDTH-1:0] load, loadNext;
  logic [WIDTH-1:0] count, countNext;
  logic             expired, expiredNext;
  logic             expSet;
  logic             tick;
  logic [7:0]       prescale;

`ifdef TIMER_PRESCALER_EN
  logic clearPresc;

  assign clearPresc = we && (addr == OFF_CTRL) && wdata[CTRL_EN];

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
    end else if (we && (addr == OFF_CTRL)) begin
      prescale <= wdata[PRESCALE_MSB:PRESCALE_LSB];
    end
  end

  timer_prescaler uPrescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (clearPresc),
    .en    (state == RUN),
    .div   (prescale),
    .tick  (tick)
  );
`else
  assign prescale = '0;
  assign tick     = (state == RUN);
`endif

  always_comb begin
    stateNext          = state;
    ctrlEnNext         = ctrlEn;
    ctrlAutoReloadNext = ctrlAutoReload;
    ctrlIrqEnNext      = ctrlIrqEn;
    loadNext           = load;
    countNext          = count;
    expiredNext        = expired;
    expSet             = 1'b0;

    if ((state == RUN) && tick) begin
      if (count == '0) begin
        expSet = 1'b1;
        if (ctrlAutoReload) begin
          countNext = load;
        end else begin
          ctrlEnNext = 1'b0;
          stateNext  = IDLE;
        end
      end else begin
        countNext = count - WIDTH'(1);
      end
    end

    // Bus writes override the tick; a STATUS clear loses to a same-cycle expiry.
    if (we) begin
      case (addr)
        OFF_CTRL: begin
          ctrlEnNext         = wdata[CTRL_EN];
          ctrlAutoReloadNext = wdata[CTRL_AUTO_RELOAD];
          ctrlIrqEnNext      = wdata[CTRL_IRQ_EN];
          stateNext          = wdata[CTRL_EN] ? RUN : IDLE;
        end
        OFF_LOAD: begin
          loadNext  = wdata;
          countNext = wdata;
        end
        OFF_STATUS: begin
          if (wdata[STATUS_EXPIRED]) expiredNext = 1'b0;
        end
        default: ;
      endcase
    end

    if (expSet) expiredNext = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ctrlEn         <= 1'b0;
      ctrlAutoReload <= 1'b0;
      ctrlIrqEn      <= 1'b0;
      load           <= '0;
      count          <= '0;
      expired        <= 1'b0;
    end else begin
      state          <= stateNext;
      ctrlEn         <= ctrlEnNext;
      ctrlAutoReload <= ctrlAutoReloadNext;
      ctrlIrqEn      <= ctrlIrqEnNext;
      load           <= loadNext;
      count          <= countNext;
      expired        <= expiredNext;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      OFF_CTRL:   rdata = WIDTH'(ctrlWord(ctrlEn, ctrlAutoReload, ctrlIrqEn, prescale));
      OFF_LOAD:   rdata = load;
      OFF_COUNT:  rdata = count;
      OFF_STATUS: rdata[STATUS_EXPIRED] = expired;
      default:    rdata = '0;
    endcase
  end

  assign irq = expired & ctrlIrqEn;

endmodule
